// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit.
// Converts EX/MEM load/store controls into a req/ack bus transaction with
// byte enables and lane-replicated write data. Sign/zero-extends load data
// for the MEM/WB register, and stalls upstream while an access is in flight.
`timescale 1ns/1ps

module mem_access_unit #(
    parameter int data_bits = 32
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic [2:0]           funct3_in,
    input  logic [data_bits-1:0] address_in,
    input  logic [data_bits-1:0] write_data_in,
    output logic                 stall_out,
    output logic                 misaligned_out,
    output logic [data_bits-1:0] data_memory_out,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [data_bits-1:0] bus_addr,
    output logic [data_bits-1:0] bus_wdata,
    output logic [3:0]           bus_be,
    input  logic [data_bits-1:0] bus_rdata,
    input  logic                 bus_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic                 access;
    logic                 is_byte;
    logic                 is_half;
    logic                 aligned;
    logic                 start;
    logic [3:0]           be_next;
    logic [data_bits-1:0] wdata_next;
    logic [2:0]           funct3_q;
    logic [1:0]           lane_q;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [data_bits-1:0] load_value;

    // Size decode and alignment; funct3 011/110/111 fall through to word.
    assign access  = mem_read_in | mem_write_in;
    assign is_byte = (funct3_in[1:0] == 2'b00);
    assign is_half = (funct3_in[1:0] == 2'b01);
    assign aligned = is_byte
                   | (is_half & ~address_in[0])
                   | (~is_byte & ~is_half & (address_in[1:0] == 2'b00));
    assign start   = (state == S_IDLE) & access & aligned;

    // The pipeline must not see a stall while reset holds the unit idle.
    assign stall_out = n_rst & (start | (state == S_WAIT));

    // Byte enables and lane-replicated store data for the access being launched.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = write_data_in;
        if (is_byte) begin
            be_next    = 4'b0001 << address_in[1:0];
            wdata_next = {4{write_data_in[7:0]}};
        end else if (is_half) begin
            be_next    = address_in[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{write_data_in[15:0]}};
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_sel   = bus_rdata[{lane_q, 3'b000} +: 8];
        half_sel   = bus_rdata[{lane_q[1], 4'b0000} +: 16];
        load_value = bus_rdata;
        case (funct3_q[1:0])
            2'b00:   load_value = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_value = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
            default: load_value = bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE lasts one cycle so the instruction is never reissued.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_WAIT;
            S_WAIT:  if (bus_ack) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus outputs, latched access info, load result and misalignment pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus_req         <= 1'b0;
            bus_we          <= 1'b0;
            bus_addr        <= '0;
            bus_wdata       <= '0;
            bus_be          <= 4'b0000;
            funct3_q        <= 3'b000;
            lane_q          <= 2'b00;
            data_memory_out <= '0;
            misaligned_out  <= 1'b0;
        end else begin
            misaligned_out <= (state == S_IDLE) & access & ~aligned;
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_write_in;
                bus_addr  <= {address_in[data_bits-1:2], 2'b00};
                bus_be    <= be_next;
                bus_wdata <= wdata_next;
                funct3_q  <= funct3_in;
                lane_q    <= address_in[1:0];
            end else if ((state == S_WAIT) && bus_ack) begin
                bus_req <= 1'b0;
                bus_we  <= 1'b0;
                if (!bus_we) begin
                    data_memory_out <= load_value;
                end
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit of the RISC-V core's MEM stage. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the EX/MEM control and address signals into a request/acknowledge data-bus transaction with byte enables, and sign- or zero-extends load data. Its load result drives the MEM/WB `data_memory_out_in` input. While a bus access is outstanding it stalls the upstream pipeline.

## Interface
- `data_bits`, 32, datapath and bus width; only 32 is supported (4 byte lanes).
- `clk` in 1: single clock; all state updates on the rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `mem_read_in` in 1: load request from EX/MEM.
- `mem_write_in` in 1: store request from EX/MEM; takes priority if both requests are high.
- `funct3_in` in 3: access size and sign. 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 are treated as word.
- `address_in` in data_bits: effective address (ALU result).
- `write_data_in` in data_bits: store data (rs2).
- `stall_out` out 1: holds the PC, IF/ID, ID/EX and EX/MEM registers.
- `misaligned_out` out 1: one-cycle pulse, misaligned access dropped.
- `data_memory_out` out data_bits: extended load result, to MEM/WB.
- `bus_req` out 1, `bus_we` out 1: request and write strobe.
- `bus_addr` out data_bits: word address, `{address_in[31:2],2'b00}`.
- `bus_wdata` out data_bits, `bus_be` out 4: lane-replicated write data and byte enables.
- `bus_rdata` in data_bits, `bus_ack` in 1: read data and completion.

## Operation
**States:** IDLE, WAIT, DONE.

**Access** is `mem_read_in | mem_write_in`.

**Aligned:**
- Byte accesses are always aligned.
- Half accesses need `address_in[0]==0`.
- Word accesses need `address_in[1:0]==0`.

**IDLE**
- Access and aligned: register `bus_req=1`, `bus_we=mem_write_in`, `bus_addr`, `bus_be`, `bus_wdata`, latch `funct3` and lane; go to WAIT.
- Access and misaligned: no bus activity; `misaligned_out=1` next cycle; stay IDLE.

**WAIT**
- Bus outputs held stable.
- On `bus_ack` sampled high: `bus_req` and `bus_we` go to 0. For a load, `data_memory_out` is updated from `bus_rdata`. Go to DONE.

**DONE**
- One cycle, then IDLE.
- Upstream advances at this edge, so the same instruction is never reissued.

**`stall_out`** (combinational): `(IDLE & access & aligned) | WAIT`. It is 0 in DONE and forced to 0 while `n_rst` is low.

**Byte enables and write data** (lane = `address_in[1:0]`):
- Byte: `bus_be = 4'b0001 << lane`; `bus_wdata` = `write_data_in[7:0]` replicated ×4.
- Half: `bus_be` = 0011 if `addr[1]==0`, else 1100; `bus_wdata` = `write_data_in[15:0]` replicated ×2.
- Word: `bus_be = 1111`; `bus_wdata = write_data_in`.
- Loads drive the same `bus_be` with `bus_we=0`.

**Load extraction:**
- Byte: `bus_rdata[8*lane+7 : 8*lane]`, sign-extended for funct3 000, zero-extended for 100.
- Half: `bus_rdata[16*addr[1]+15 : 16*addr[1]]`, sign-extended for 001, zero-extended for 101.
- Word: unchanged.

**`data_memory_out`** changes only on a load ack. Stores and misaligned loads leave it unchanged.

**`bus_ack`** is ignored in IDLE and DONE.

## Timing
- **Reset (async, immediate):** state IDLE; `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, `data_memory_out` and `misaligned_out` all 0.
- **Reset mid-WAIT:** the transaction is abandoned; a later ack is ignored.
- **Minimum access**, ack in the first WAIT cycle: 3 cycles (IDLE, WAIT, DONE). `stall_out` is high for 2 cycles; `data_memory_out` is valid from the DONE cycle onward.
- **Each extra WAIT cycle** without ack adds one stall cycle.
- **`bus_req`** is high for exactly the WAIT cycles. Address, data, enables and strobe do not change while it is high.
- **Back-to-back accesses:** the next instruction is evaluated in the IDLE cycle after DONE, so there is one non-stalled DONE cycle between accesses.
- **Misaligned access:** no stall; `misaligned_out` pulses high in the cycle after it is presented.
- **Both requests high:** performed as a store.

## Test plan
- **LW, zero-wait:** addr 0x100, `bus_rdata`=0xDEADBEEF with ack in the first WAIT cycle. Expect `bus_req` high 1 cycle, `bus_addr`=0x100, `bus_be`=1111, `stall_out` high 2 cycles, `data_memory_out`=0xDEADBEEF in DONE.
- **LB/LBU:** addr 0x103, `bus_rdata`=0x80FF0000. LB gives 0xFFFFFF80; LBU gives 0x00000080; `bus_be`=1000.
- **SH with 3 wait cycles:** addr 0x102, data 0x1234ABCD. Expect `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD held 4 cycles, `stall_out` high 5 cycles, `data_memory_out` unchanged.
- **Misaligned LW:** addr 0x101. Expect no `bus_req`, `stall_out`=0, `misaligned_out` one-cycle pulse next cycle.
- **Reset mid-WAIT, then late ack:** assert `n_rst`=0 mid-WAIT, release it, then ack. Expect `bus_req`=0 immediately, state IDLE, ack ignored, `data_memory_out`=0.
- **Back-to-back SW then LHU:** SW 0x200, then LHU 0x206 with `bus_rdata`=0xF00D0000. Expect two separate transactions with one DONE cycle between, LHU result 0x0000F00D.
